writeback_arbiter: RTL

//  Write-side producer for the integer register file: merges ALU results and load-unit results

---
 rtl/writeback_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU results with extended load results from a small FIFO,
// with a starvation counter that forces a pending load through under continuous ALU traffic.
module writeback_arbiter #(
  parameter int LD_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             alu_valid_in,
  output logic                             alu_ready_out,
  input  logic [4:0]                       alu_rd_addr_in,
  input  logic [31:0]                      alu_result_in,
  input  logic                             ld_valid_in,
  output logic                             ld_ready_out,
  input  logic [4:0]                       ld_rd_addr_in,
  input  logic [31:0]                      ld_data_in,
  input  logic [1:0]                       ld_offset_in,
  input  logic [2:0]                       ld_funct3_in,
  output logic [4:0]                       rd_addr_out,
  output logic                             wr_en_out,
  output logic [31:0]                      rd_out,
  output logic                             ld_err_out,
  output logic [$clog2(LD_FIFO_DEPTH):0]   ld_fifo_count_out
);

  localparam int PW = $clog2(LD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } ld_entry_t;

  ld_entry_t       mem [LD_FIFO_DEPTH];
  ld_entry_t       push_entry;
  ld_entry_t       pop_entry;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            fifo_ne;
  logic            force_ld;
  logic            sel_ld;
  logic            alu_accept;
  logic            push;

  // NOTE: every variable an always_comb writes gets a default first, so no path can infer a latch.
  always_comb begin
    byte_sel = 8'h00;
    unique case (ld_offset_in)
      2'd0: byte_sel = ld_data_in[7:0];
      2'd1: byte_sel = ld_data_in[15:8];
      2'd2: byte_sel = ld_data_in[23:16];
      2'd3: byte_sel = ld_data_in[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = ld_offset_in[1] ? ld_data_in[31:16] : ld_data_in[15:0];

    push_entry      = '0;
    push_entry.rd   = ld_rd_addr_in;
    case (ld_funct3_in)
      3'd0:    push_entry.data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    push_entry.data = {{16{half_sel[15]}}, half_sel};
      3'd2:    push_entry.data = ld_data_in;
      3'd4:    push_entry.data = {24'h0, byte_sel};
      3'd5:    push_entry.data = {16'h0, half_sel};
      default: push_entry.err  = 1'b1;
    endcase
  end

  assign fifo_ne      = (count != '0);
  assign force_ld     = fifo_ne && (starve_cnt >= LIMIT_C);
  assign sel_ld       = force_ld || (fifo_ne && !alu_valid_in);
  assign alu_accept   = alu_valid_in && !force_ld;
  // Readiness comes from the registered count only, so a full FIFO refuses a push even while popping.
  assign push         = ld_valid_in && ld_ready_out;
  assign ld_ready_out = (count < DEPTH_C);
  assign alu_ready_out     = !force_ld;
  assign ld_fifo_count_out = count;
  assign pop_entry    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (sel_ld) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(sel_ld);
      if (!fifo_ne || sel_ld)
        starve_cnt <= '0;
      else if (starve_cnt < LIMIT_C)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // NOTE: FIFO storage is not reset; the reset pointers and count mark every entry invalid.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_addr_out <= '0;
      wr_en_out   <= 1'b0;
      rd_out      <= '0;
      ld_err_out  <= 1'b0;
    end else if (sel_ld) begin
      rd_addr_out <= pop_entry.rd;
      rd_out      <= pop_entry.data;
      wr_en_out   <= (pop_entry.rd != 5'd0);
      ld_err_out  <= pop_entry.err;
    end else if (alu_accept) begin
      rd_addr_out <= alu_rd_addr_in;
      rd_out      <= alu_result_in;
      wr_en_out   <= (alu_rd_addr_in != 5'd0);
      ld_err_out  <= 1'b0;
    end else begin
      wr_en_out   <= 1'b0;
      ld_err_out  <= 1'b0;
    end
  end

endmodule
